// File: rtl/pe_axi_pkg.sv
// Shared AXI4 constants and the result-writer FSM encoding.
package pe_axi_pkg;

   localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
   localparam logic [2:0] AXI_SIZE_8B       = 3'd3;
   localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR   = 2'b10;
   localparam logic [3:0] AXI_CACHE_DEFAULT = 4'd3;
   localparam logic [2:0] AXI_PROT_DEFAULT  = 3'd0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_AW,
      ST_W,
      ST_B,
      ST_DONE
   } wb_state_t;

   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp != AXI_RESP_OKAY;
   endfunction

endpackage

// File: rtl/pe_wb_fifo.sv
// Result-vector FIFO; the head word is visible combinationally so a beat can
// be formed from it without an extra read cycle.
module pe_wb_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             wr_data,
   output logic [WIDTH-1:0]             rd_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    fill;

   assign full    = (fill == CW'(DEPTH));
   assign empty   = (fill == '0);
   assign count   = fill;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
      end
   end

endmodule

// File: rtl/pe_result_writer.sv
// Buffers PE result vectors and writes them out as fixed-length AXI4 INCR bursts.
// Build option PE_WB_ERR_ABORT_EN: a non-OKAY write response ends the job early.
module pe_result_writer
   import pe_axi_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int VECTOR_WIDTH   = 4,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int BURST_BEATS    = 8,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               res_valid,
   input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0] res_data,
   output logic                               res_ready,
   input  logic [AXI_ADDR_WIDTH-1:0]          base_addr,
   input  logic [7:0]                         num_bursts,
   input  logic                               start,
   output logic                               done,
   output logic [7:0]                         wb_count,
   output logic                               error,
   output logic [AXI_ID_WIDTH-1:0]            axi_awid,
   output logic [AXI_ADDR_WIDTH-1:0]          axi_awaddr,
   output logic [7:0]                         axi_awlen,
   output logic [2:0]                         axi_awsize,
   output logic [1:0]                         axi_awburst,
   output logic [3:0]                         axi_awcache,
   output logic [2:0]                         axi_awprot,
   output logic                               axi_awvalid,
   input  logic                               axi_awready,
   output logic [AXI_DATA_WIDTH-1:0]          axi_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0]        axi_wstrb,
   output logic                               axi_wlast,
   output logic                               axi_wvalid,
   input  logic                               axi_wready,
   input  logic [AXI_ID_WIDTH-1:0]            axi_bid,
   input  logic [1:0]                         axi_bresp,
   input  logic                               axi_bvalid,
   output logic                               axi_bready
);

   localparam int VEC_W  = VECTOR_WIDTH * DATA_WIDTH;
   localparam int LANES  = AXI_DATA_WIDTH / DATA_WIDTH;
   localparam int BEAT_W = $clog2(BURST_BEATS);
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam logic [AXI_ADDR_WIDTH-1:0] BURST_BYTES = AXI_ADDR_WIDTH'(BURST_BEATS * 8);
   localparam logic [CNT_W-1:0]          FILL_LEVEL  = CNT_W'(BURST_BEATS / 2);
   localparam logic [BEAT_W-1:0]         LAST_BEAT   = BEAT_W'(BURST_BEATS - 1);

   wb_state_t                 state;
   logic [AXI_ADDR_WIDTH-1:0] cur_addr;
   logic [7:0]                bursts;
   logic [BEAT_W-1:0]         beat;
   logic [VEC_W-1:0]          head;
   logic [CNT_W-1:0]          fifo_count;
   logic                      full;
   logic                      empty;
   logic                      push;
   logic                      pop;
   logic                      resp_err;
   logic                      end_job;
   logic                      unused_bid;

   assign res_ready  = !full;
   assign push       = res_valid && !full;
   // A vector spans two beats; it leaves the FIFO once its upper half is accepted.
   assign pop        = axi_wvalid && axi_wready && beat[0] && !empty;
   assign resp_err   = resp_is_err(axi_bresp);
   assign unused_bid = ^axi_bid;

`ifdef PE_WB_ERR_ABORT_EN
   assign end_job = (wb_count + 8'd1 == bursts) || resp_err;
`else
   assign end_job = (wb_count + 8'd1 == bursts);
`endif

   assign axi_awaddr  = cur_addr;
   assign axi_awlen   = 8'(BURST_BEATS - 1);
   assign axi_awsize  = AXI_SIZE_8B;
   assign axi_awburst = AXI_BURST_INCR;
   assign axi_awcache = AXI_CACHE_DEFAULT;
   assign axi_awprot  = AXI_PROT_DEFAULT;
   assign axi_wstrb   = '1;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign axi_wdata[gi*DATA_WIDTH +: DATA_WIDTH] = beat[0]
         ? head[(LANES + gi)*DATA_WIDTH +: DATA_WIDTH]
         : head[gi*DATA_WIDTH +: DATA_WIDTH];
   end

   pe_wb_fifo #(
      .WIDTH (VEC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .wr_data (res_data),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .count   (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cur_addr    <= '0;
         bursts      <= '0;
         beat        <= '0;
         axi_awid    <= '0;
         wb_count    <= '0;
         done        <= 1'b0;
         error       <= 1'b0;
         axi_awvalid <= 1'b0;
         axi_wvalid  <= 1'b0;
         axi_wlast   <= 1'b0;
         axi_bready  <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  cur_addr <= base_addr;
                  bursts   <= num_bursts;
                  axi_awid <= axi_awid + 1'b1;
                  wb_count <= '0;
                  error    <= 1'b0;
                  if (num_bursts == 8'd0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_FILL;
                  end
               end
            end
            // Wait for a full burst's worth of data so W never stalls on the FIFO.
            ST_FILL: begin
               if (fifo_count >= FILL_LEVEL) begin
                  state       <= ST_AW;
                  axi_awvalid <= 1'b1;
               end
            end
            ST_AW: begin
               if (axi_awready) begin
                  state       <= ST_W;
                  axi_awvalid <= 1'b0;
                  axi_wvalid  <= 1'b1;
                  axi_wlast   <= 1'b0;
                  beat        <= '0;
               end
            end
            ST_W: begin
               if (axi_wready) begin
                  if (axi_wlast) begin
                     state      <= ST_B;
                     axi_wvalid <= 1'b0;
                     axi_wlast  <= 1'b0;
                     axi_bready <= 1'b1;
                     beat       <= '0;
                  end else begin
                     beat      <= beat + 1'b1;
                     axi_wlast <= (beat == LAST_BEAT - 1'b1);
                  end
               end
            end
            ST_B: begin
               if (axi_bvalid) begin
                  axi_bready <= 1'b0;
                  wb_count   <= wb_count + 8'd1;
                  cur_addr   <= cur_addr + BURST_BYTES;
                  if (resp_err) begin
                     error <= 1'b1;
                  end
                  if (end_job) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_FILL;
                  end
               end
            end
            ST_DONE: begin
               if (!start) begin
                  state <= ST_IDLE;
                  done  <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
